// File: rtl/dram_port_pkg.sv
// Shared types and widths for the DRAM user-port stand-in responder.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package dram_port_pkg;

   // Width of the controller user-port data and address.
   localparam int WORD_SIZE  = 256;
   localparam int ADDR_WIDTH = 25;
   localparam int SEL_W      = WORD_SIZE / 8;

   // Responder sequencing: fake calibration, then one request at a time.
   typedef enum logic [2:0] {
      INIT,
      IDLE,
      WAIT,
      RESP,
      ERR
   } resp_state_t;

   // One captured Wishbone request, held for the whole transaction.
   typedef struct packed {
      logic                  we;
      logic [ADDR_WIDTH-1:0] adr;
      logic [WORD_SIZE-1:0]  dat;
      logic [SEL_W-1:0]      sel;
   } wb_req_t;

endpackage

// File: rtl/dram_user_port_responder_be_ram.sv
// Single-port byte-enable RAM backing the responder, one word per address.
// Latency: read data appears on o_rdat one cycle after i_rd_en; writes commit at the clock edge.
// Backpressure: none; the caller never issues a read and a write in the same cycle.
module be_ram
   import dram_port_pkg::*;
#(
   parameter int DEPTH_LOG2 = 10
) (
   input  logic                  user_clk,
   input  logic                  rst_n,
   input  logic                  i_rd_en,
   input  logic                  i_wr_en,
   input  logic [DEPTH_LOG2-1:0] i_addr,
   input  logic [WORD_SIZE-1:0]  i_wdat,
   input  logic [SEL_W-1:0]      i_sel,
   output logic [WORD_SIZE-1:0]  o_rdat
);

   localparam int DEPTH = 1 << DEPTH_LOG2;

   // Storage is not reset: contents survive a responder reset, like real DRAM.
   logic [WORD_SIZE-1:0] r_mem [0:DEPTH-1];
   logic [WORD_SIZE-1:0] r_rdat;

   // Byte-lane write: only lanes with their select bit set are updated.
   always_ff @(posedge user_clk) begin
      if (i_wr_en) begin
         for (int b = 0; b < SEL_W; b++) begin
            if (i_sel[b]) begin
               r_mem[i_addr][8*b +: 8] <= i_wdat[8*b +: 8];
            end
         end
      end
   end

   // Output register loads only on a read, so it holds the last read word
   // until the next read; its synchronous clear maps onto the BRAM output reset.
   always_ff @(posedge user_clk) begin
      if (!rst_n) begin
         r_rdat <= '0;
      end else if (i_rd_en) begin
         r_rdat <= r_mem[i_addr];
      end
   end

   assign o_rdat = r_rdat;

endmodule

// File: rtl/dram_user_port_responder.sv
// Wishbone stand-in for the DRAM controller user port, backed by on-chip byte-enable RAM.
// Latency: ack READ_LATENCY / WRITE_LATENCY cycles after the strobe is sampled; err one cycle after.
// Backpressure: one outstanding request; further strobes are ignored until the responder is back in IDLE.
module dram_user_port_responder
   import dram_port_pkg::*;
#(
   parameter int MEM_DEPTH_LOG2 = 10,
   parameter int READ_LATENCY   = 4,   // at least 2: the sync-read RAM needs a cycle ahead of the ack
   parameter int WRITE_LATENCY  = 2,   // at least 1
   parameter int INIT_CYCLES    = 64   // at least 1
) (
   input  logic                  user_clk,
   input  logic                  rst_n,
   output logic                  init_done,
   input  logic                  wb_cyc_i,
   input  logic                  wb_stb_i,
   input  logic                  wb_we_i,
   input  logic [ADDR_WIDTH-1:0] wb_adr_i,
   input  logic [WORD_SIZE-1:0]  wb_dat_i,
   input  logic [SEL_W-1:0]      wb_sel_i,
   output logic [WORD_SIZE-1:0]  wb_dat_o,
   output logic                  wb_ack_o,
   output logic                  wb_err_o
);

   localparam int LAT_MAX = (READ_LATENCY > WRITE_LATENCY) ? READ_LATENCY : WRITE_LATENCY;
   localparam int CNT_W   = $clog2(LAT_MAX + 1);
   localparam int INIT_W  = $clog2(INIT_CYCLES + 1);

   // First word address past the end of the backing RAM; one extra bit so it is representable.
   localparam logic [ADDR_WIDTH:0] DEPTH_WORDS = (ADDR_WIDTH + 1)'(1) << MEM_DEPTH_LOG2;
   localparam logic [INIT_W-1:0]   INIT_LAST   = INIT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0]    RD_LOAD     = CNT_W'(READ_LATENCY - 1);
   localparam logic [CNT_W-1:0]    WR_LOAD     = CNT_W'(WRITE_LATENCY - 1);

   resp_state_t          r_state;
   wb_req_t              r_req;
   logic [INIT_W-1:0]    r_init_cnt;
   logic [CNT_W-1:0]     r_lat_cnt;
   logic                 r_init_done;
   logic                 r_ack;
   logic                 r_err;

   logic                 w_req_vld;
   logic                 w_adr_oob;
   logic [CNT_W-1:0]     w_lat_load;
   logic                 w_req_in_rng;
   logic                 w_rd_en;
   logic                 w_wr_en;
   logic [WORD_SIZE-1:0] w_ram_rdat;

   assign w_req_vld  = wb_cyc_i && wb_stb_i;
   assign w_adr_oob  = {1'b0, wb_adr_i} >= DEPTH_WORDS;
   assign w_lat_load = wb_we_i ? WR_LOAD : RD_LOAD;

   // The latched address was range-checked on capture; re-checking it here keeps a
   // corrupted request from ever touching the RAM and costs a single comparator.
   assign w_req_in_rng = {1'b0, r_req.adr} < DEPTH_WORDS;

   // The read is launched in the last WAIT cycle so the RAM output register is
   // valid in the RESP cycle. Dropping wb_cyc_i in that cycle aborts it too.
   assign w_rd_en = rst_n && (r_state == WAIT) && (r_lat_cnt == CNT_W'(1)) &&
                    !r_req.we && wb_cyc_i && w_req_in_rng;

   // A write commits in the acking cycle; reset in that cycle discards it.
   assign w_wr_en = rst_n && (r_state == RESP) && r_req.we && w_req_in_rng;

   // Request sequencing with registered ack/err/init_done.
   always_ff @(posedge user_clk) begin
      if (!rst_n) begin
         r_state     <= INIT;
         r_req       <= '0;
         r_init_cnt  <= '0;
         r_lat_cnt   <= '0;
         r_init_done <= 1'b0;
         r_ack       <= 1'b0;
         r_err       <= 1'b0;
      end else begin
         // ack and err are single-cycle pulses by default.
         r_ack <= 1'b0;
         r_err <= 1'b0;
         case (r_state)
            // Fake calibration; requests stay pending on the bus until IDLE sees them.
            INIT: begin
               if (r_init_cnt == INIT_LAST) begin
                  r_init_done <= 1'b1;
                  r_state     <= IDLE;
               end else begin
                  r_init_cnt <= r_init_cnt + 1'b1;
               end
            end
            IDLE: begin
               if (w_req_vld) begin
                  r_req <= '{we: wb_we_i, adr: wb_adr_i, dat: wb_dat_i, sel: wb_sel_i};
                  if (w_adr_oob) begin
                     r_err   <= 1'b1;
                     r_state <= ERR;
                  end else if (w_lat_load == '0) begin
                     r_ack   <= 1'b1;
                     r_state <= RESP;
                  end else begin
                     r_lat_cnt <= w_lat_load;
                     r_state   <= WAIT;
                  end
               end
            end
            // The master may give up while waiting; that request is simply forgotten.
            WAIT: begin
               if (!wb_cyc_i) begin
                  r_state <= IDLE;
               end else if (r_lat_cnt == CNT_W'(1)) begin
                  r_ack   <= 1'b1;
                  r_state <= RESP;
               end else begin
                  r_lat_cnt <= r_lat_cnt - 1'b1;
               end
            end
            RESP: r_state <= IDLE;
            ERR:  r_state <= IDLE;
            default: r_state <= INIT;
         endcase
      end
   end

   be_ram #(
      .DEPTH_LOG2 (MEM_DEPTH_LOG2)
   ) u_be_ram (
      .user_clk (user_clk),
      .rst_n    (rst_n),
      .i_rd_en  (w_rd_en),
      .i_wr_en  (w_wr_en),
      .i_addr   (r_req.adr[MEM_DEPTH_LOG2-1:0]),
      .i_wdat   (r_req.dat),
      .i_sel    (r_req.sel),
      .o_rdat   (w_ram_rdat)
   );

   assign init_done = r_init_done;
   assign wb_ack_o  = r_ack;
   assign wb_err_o  = r_err;
   assign wb_dat_o  = w_ram_rdat;

endmodule

// File: tb/tb_dram_user_port_responder.sv
// Self-checking bench for dram_user_port_responder against a transaction-level memory model.
// Latency: checks ack/err timing relative to the cycle the strobe is presented in IDLE.
// Backpressure: one request at a time, held until ack/err, as a Wishbone classic master.
module tb_dram_user_port_responder;

   localparam int RL    = 4;
   localparam int WL    = 2;
   localparam int INITC = 64;
   localparam int DEPTH = 1024;
   localparam int POOL  = 32;

   logic         user_clk = 1'b0;
   logic         rst_n    = 1'b0;
   logic         init_done;
   logic         cyc      = 1'b0;
   logic         stb      = 1'b0;
   logic         we       = 1'b0;
   logic [24:0]  adr      = '0;
   logic [255:0] dat_i    = '0;
   logic [31:0]  sel      = '0;
   logic [255:0] dat_o;
   logic         ack;
   logic         err;

   int           n_checks  = 0;
   int           n_pass    = 0;
   logic         both_seen = 1'b0;

   logic [255:0] mdl_mem [0:DEPTH-1];

   dram_user_port_responder dut (
      .user_clk  (user_clk),
      .rst_n     (rst_n),
      .init_done (init_done),
      .wb_cyc_i  (cyc),
      .wb_stb_i  (stb),
      .wb_we_i   (we),
      .wb_adr_i  (adr),
      .wb_dat_i  (dat_i),
      .wb_sel_i  (sel),
      .wb_dat_o  (dat_o),
      .wb_ack_o  (ack),
      .wb_err_o  (err)
   );

   always #5 user_clk = ~user_clk;

   always @(negedge user_clk) begin
      if (ack && err) both_seen <= 1'b1;
   end

   task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got=%h exp=%h", tag, got, exp);
   endtask

   task automatic tick();
      @(posedge user_clk);
      #1;
   endtask

   function automatic logic [255:0] rand256();
      logic [255:0] r;
      for (int i = 0; i < 8; i++) r[32*i +: 32] = $urandom;
      return r;
   endfunction

   function automatic logic [255:0] merge(input logic [255:0] old, input logic [255:0] nd, input logic [31:0] s);
      logic [255:0] r;
      r = old;
      for (int b = 0; b < 32; b++) if (s[b]) r[8*b +: 8] = nd[8*b +: 8];
      return r;
   endfunction

   // Present a request in the current (IDLE) cycle and hold it until ack/err or a bound.
   task automatic run_req(input logic w, input logic [24:0] a, input logic [255:0] d, input logic [31:0] s,
                          output int lat, output logic is_err, output logic [255:0] rd);
      lat = -1; is_err = 1'b0; rd = '0;
      we = w; adr = a; dat_i = d; sel = s; cyc = 1'b1; stb = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (ack || err) begin
            lat = k; is_err = err; rd = dat_o;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      tick();
      check("pulse_1cyc", 256'(ack | err), '0);
   endtask

   // One transaction checked against the model, then the model is updated.
   task automatic do_op(input string tag, input logic w, input logic [24:0] a, input logic [255:0] d,
                        input logic [31:0] s, output logic [255:0] rd);
      int   lat;
      logic is_err;
      logic oob;
      oob = (a >= 25'(DEPTH));
      run_req(w, a, d, s, lat, is_err, rd);
      check({tag, "_lat"}, 256'(lat), 256'(oob ? 1 : (w ? WL : RL)));
      check({tag, "_err"}, 256'(is_err), 256'(oob));
      if (!oob && !w) check({tag, "_rdat"}, rd, mdl_mem[a % DEPTH]);
      if (!oob && w)  mdl_mem[a % DEPTH] = merge(mdl_mem[a % DEPTH], d, s);
   endtask

   initial begin
      logic [255:0] rd;
      logic [255:0] d;
      logic [31:0]  s;
      logic [24:0]  a;
      int           first_done;
      int           ack_cyc;
      int           hits;
      int           k1;
      int           k2;

      // Reset state.
      rst_n = 1'b0;
      repeat (3) tick();
      check("rst_ack", 256'(ack), '0);
      check("rst_err", 256'(err), '0);
      check("rst_init", 256'(init_done), '0);
      check("rst_dato", dat_o, '0);

      // Test 1: release in cycle 0, strobe from cycle 10, init_done at 64, ack at 64+RL.
      rst_n = 1'b1;
      repeat (10) tick();
      we = 1'b0; adr = 25'h005; sel = '1; cyc = 1'b1; stb = 1'b1;
      first_done = -1; ack_cyc = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (init_done && first_done < 0) first_done = 10 + k;
         if (ack) begin
            ack_cyc = 10 + k;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      tick();
      check("init_cycle", 256'(first_done), 256'(INITC));
      check("init_ack_cycle", 256'(ack_cyc), 256'(INITC + RL));

      // Give every pool word known contents.
      for (int i = 0; i < POOL; i++) do_op("prime", 1'b1, 25'(i), rand256(), '1, rd);

      // Test 2: full write then read back.
      do_op("t2_wr", 1'b1, 25'h005, {32{8'hA5}}, '1, rd);
      do_op("t2_rd", 1'b0, 25'h005, '0, '0, rd);
      check("t2_const", rd, {32{8'hA5}});

      // Test 3: single-lane write into an all-ones word.
      do_op("t3_ff", 1'b1, 25'h007, {32{8'hFF}}, '1, rd);
      d = rand256();
      d[7:0] = 8'h3C;
      do_op("t3_wr", 1'b1, 25'h007, d, 32'h1, rd);
      do_op("t3_rd", 1'b0, 25'h007, '0, '0, rd);
      check("t3_const", rd, {{31{8'hFF}}, 8'h3C});

      // Test 4: out-of-range read and write give err, word 0 untouched.
      do_op("t4_rd", 1'b0, 25'h400, '0, '0, rd);
      do_op("t4_wr", 1'b1, 25'h400, rand256(), '1, rd);
      do_op("t4_w0", 1'b0, 25'h000, '0, '0, rd);

      // Test 5: write abandoned by dropping cyc in T+1.
      we = 1'b1; adr = 25'h009; dat_i = rand256(); sel = '1; cyc = 1'b1; stb = 1'b1;
      tick();
      hits = (ack || err) ? 1 : 0;
      cyc = 1'b0; stb = 1'b0;
      for (int k = 0; k < 8; k++) begin
         tick();
         if (ack || err) hits++;
      end
      check("t5_no_ack", 256'(hits), '0);
      do_op("t5_rd", 1'b0, 25'h009, '0, '0, rd);

      // Test 6: back-to-back reads with strobe held across the first ack.
      we = 1'b0; adr = 25'h005; sel = '0; cyc = 1'b1; stb = 1'b1;
      k1 = -1; k2 = -1;
      for (int k = 1; k <= 40; k++) begin
         tick();
         if (ack && k1 < 0) begin
            k1 = k;
            check("t6_d1", dat_o, mdl_mem[5]);
            adr = 25'h006;
         end else if (ack) begin
            k2 = k;
            check("t6_d2", dat_o, mdl_mem[6]);
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      tick();
      check("t6_k1", 256'(k1), 256'(RL));
      check("t6_k2", 256'(k2), 256'(2 * RL + 1));
      check("t6_hold", dat_o, mdl_mem[6]);

      // Randomized traffic over the pool plus out-of-range addresses.
      for (int i = 0; i < 150; i++) begin
         if ($urandom_range(0, 7) == 0) a = 25'($urandom_range(33554431, DEPTH));
         else                           a = 25'($urandom_range(POOL - 1, 0));
         case ($urandom_range(0, 3))
            0:       s = '1;
            1:       s = '0;
            default: s = $urandom;
         endcase
         do_op("rnd", 1'($urandom_range(0, 1)), a, rand256(), s, rd);
         repeat ($urandom_range(0, 2)) tick();
      end

      check("init_sticky", 256'(init_done), 256'(1));
      check("ack_err_excl", 256'(both_seen), '0);

      // Reset in the last WAIT cycle of a read: nothing completes, back to INIT.
      we = 1'b0; adr = 25'h005; sel = '0; cyc = 1'b1; stb = 1'b1;
      repeat (3) tick();
      rst_n = 1'b0;
      tick();
      check("rstw_ack", 256'(ack | err), '0);
      check("rstw_init", 256'(init_done), '0);
      check("rstw_dato", dat_o, '0);
      rst_n = 1'b1;
      ack_cyc = -1;
      for (int k = 1; k <= 200; k++) begin
         tick();
         if (ack || err) begin
            ack_cyc = k;
            rd = dat_o;
            break;
         end
      end
      cyc = 1'b0; stb = 1'b0;
      tick();
      check("rstw_reinit", 256'(ack_cyc), 256'(INITC + RL));
      check("rstw_ram_kept", rd, mdl_mem[5]);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
